ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction-fetch sequencer that sits directly upstream of the instruction cache.
- Owns the PC and issues one fetch at a time to the cache over a req/addr/valid/data interface.
- Holds the returned instruction in an output register and hands it to the decode stage over a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from downstream. An in-flight cache fill is never aborted; its data is discarded instead.

Parameters:
- ADDR_WIDTH, 32, PC and fetch address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h3000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_req  out  1  one-cycle fetch request pulse.
- icache_addr  out  ADDR_WIDTH  fetch address; stable from req until icache_valid.
- icache_data  in  DATA_WIDTH  fetched instruction; meaningful only when icache_valid=1.
- icache_valid  in  1  fetch complete; may assert in the req cycle (hit) or later (miss fill).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_inst  out  DATA_WIDTH  held instruction.
- out_pc  out  ADDR_WIDTH  PC of out_inst.
- redirect_valid  in  1  one-cycle redirect pulse.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 0.

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is asynchronous, active-high.
- Registers: state, pc, fetch_addr, kill, inst_r, pc_r.
  - icache_addr = fetch_addr.
  - icache_req = (state==ISSUE).
  - out_valid = (state==HOLD) & ~redirect_valid.
- Reset values:
  - state=IDLE, pc=fetch_addr=RESET_PC, kill=0, inst_r=0, pc_r=0.
  - Outputs during reset: icache_req=0, out_valid=0, out_inst=0, out_pc=0.
- State IDLE: go to ISSUE next cycle. A redirect here loads pc and fetch_addr with the target.
- State ISSUE: icache_req=1.
  - icache_valid=1 in the same cycle with no redirect: inst_r<=icache_data, pc_r<=fetch_addr, go to HOLD.
  - icache_valid=1 with redirect: drop data, pc=fetch_addr<=redirect_pc, stay in ISSUE.
  - icache_valid=0 with no redirect: go to WAIT.
  - icache_valid=0 with redirect: pc<=redirect_pc, kill<=1, go to WAIT; fetch_addr unchanged.
- State WAIT: icache_req=0, fetch_addr held.
  - Redirect: pc<=redirect_pc, kill<=1. Latest redirect wins.
  - icache_valid=1 and (kill | redirect_valid): drop data, kill<=0, fetch_addr<=(redirect target if present, else pc), go to ISSUE.
  - icache_valid=1 otherwise: capture as in ISSUE, go to HOLD.
- State HOLD: out_inst=inst_r, out_pc=pc_r.
  - out_valid & out_ready: pc=fetch_addr<=pc_r+4, go to ISSUE.
  - Redirect (any out_ready): instruction not delivered, pc=fetch_addr<=redirect_pc, go to ISSUE.
  - Otherwise hold; inst_r and pc_r must not change while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Hit: req cycle to out_valid is 1 cycle.
  - Steady-state hit throughput is one instruction per 2 cycles.
  - Miss latency is set by the cache.
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0.
- Never more than one outstanding fetch. icache_req never asserts while in WAIT or HOLD.
- Reset asserted mid-fill forces IDLE immediately. The cache is reset by the same event; no data is retained.

Test Plan:
- Reset release, cache returns valid in req cycle with data 0x00000413 ->
  - req at cycle 1 with addr 0x30000000;
  - out_valid at cycle 2 with out_pc=0x30000000, out_inst=0x00000413.
- Three hits with out_ready=1 ->
  - out_pc sequence 0x30000000, 0x30000004, 0x30000008;
  - exactly one req pulse per instruction.
- Miss, icache_valid 9 cycles after req ->
  - addr stays 0x30000000 and req=0 throughout WAIT;
  - out_valid asserts 1 cycle after valid.
- Redirect to 0x30001002 during WAIT ->
  - returned data dropped, out_valid stays 0;
  - next req addr=0x30001000; the following delivered out_pc=0x30001000.
- HOLD with out_ready=0 for 5 cycles, then out_ready=1 together with redirect to 0x80000000 ->
  - out_inst stable while stalled;
  - out_valid=0 in the redirect cycle;
  - next req addr=0x80000000.
- pc=0xFFFFFFFC accepted ->
  - next req addr=0x00000000;
  - rst pulse mid-miss -> icache_req=0 and out_valid=0 immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and single-outstanding fetch sequencer in front of
// the I-cache. Ports: clk/rst, icache req/addr/data/valid, decode
// out_valid/out_ready/out_inst/out_pc, redirect_valid/redirect_pc.
module ifu_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  icache_req,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic [DATA_WIDTH-1:0] icache_data,
  input  logic                  icache_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fa_q, fa_d;
  logic [ADDR_WIDTH-1:0] pcr_q, pcr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] tgt;

  // Targets are always word aligned.
  assign tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  assign icache_req  = (state_q == S_ISSUE);
  assign icache_addr = fa_q;
  assign out_valid   = (state_q == S_HOLD) & ~redirect_valid;
  assign out_inst    = inst_q;
  assign out_pc      = pcr_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    pcr_d   = pcr_q;
    inst_d  = inst_q;
    kill_d  = kill_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
        if (redirect_valid) begin
          pc_d = tgt;
          fa_d = tgt;
        end
      end
      S_ISSUE: begin
        if (icache_valid) begin
          if (redirect_valid) begin
            pc_d = tgt;
            fa_d = tgt;
          end else begin
            inst_d  = icache_data;
            pcr_d   = fa_q;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
          // Fill stays in flight on the old address; mark it stale.
          if (redirect_valid) begin
            pc_d   = tgt;
            kill_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
        if (icache_valid) begin
          if (kill_q | redirect_valid) begin
            kill_d  = 1'b0;
            fa_d    = redirect_valid ? tgt : pc_q;
            state_d = S_ISSUE;
          end else begin
            inst_d  = icache_data;
            pcr_d   = fa_q;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          fa_d    = tgt;
          state_d = S_ISSUE;
        end else if (out_ready) begin
          pc_d    = pcr_q + ADDR_WIDTH'(4);
          fa_d    = pcr_q + ADDR_WIDTH'(4);
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      fa_q    <= RESET_PC;
      pcr_q   <= '0;
      inst_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      pcr_q   <= pcr_d;
      inst_q  <= inst_d;
      kill_q  <= kill_d;
    end
  end

endmodule
